// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache and its refill engine.
// State encodings for the byte-serial refill FSM live here too.
package icache_pkg;

    typedef logic [31:0] ADDR_TP;
    typedef logic [31:0] WORD_TP;
    typedef logic [7:0]  BYTE_TP;

    localparam logic   TRUE      = 1'b1;
    localparam logic   FALSE     = 1'b0;
    localparam ADDR_TP ZERO_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_WAIT = 2'd2,
        IC_FILL = 2'd3
    } ic_state_e;

endpackage

// File: rtl/icache_refill.sv
// Refill engine: fetches one 32-bit line as four byte reads from the memory
// controller, assembles it little-endian and hands it to the array owner.
module icache_refill
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 32 - 2 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               start,
    input  logic [31:0]        start_addr,
    output logic               mem_en,
    output logic [31:0]        mem_addr,
    input  logic               mem_valid,
    input  logic [7:0]         mem_din,
    output logic               fill_en,
    output logic [INDEX_W-1:0] fill_idx,
    output logic [TAG_W-1:0]   fill_tag,
    output logic [31:0]        fill_data
);

    ic_state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    WORD_TP     buf_q, buf_d;
    ADDR_TP     miss_addr_q, miss_addr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IC_IDLE;
            cnt_q       <= 2'd0;
            buf_q       <= '0;
            miss_addr_q <= ZERO_ADDR;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        miss_addr_d = miss_addr_q;
        case (state_q)
            IC_IDLE: begin
                // Misses seen while busy are dropped; the fetcher re-asks.
                if (start) begin
                    state_d     = IC_REQ;
                    miss_addr_d = {start_addr[31:2], 2'b00};
                    cnt_d       = 2'd0;
                end
            end
            IC_REQ: begin
                state_d = IC_WAIT;
            end
            IC_WAIT: begin
                if (mem_valid) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = mem_din;
                    if (cnt_q == 2'd3) begin
                        state_d = IC_FILL;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = IC_REQ;
                    end
                end
            end
            IC_FILL: begin
                state_d = IC_IDLE;
            end
            default: begin
                state_d = IC_IDLE;
            end
        endcase
    end

    // Request outputs derive from state so an async reset drops mem_en at once.
    assign mem_en    = (state_q == IC_REQ) || (state_q == IC_WAIT);
    assign mem_addr  = mem_en ? (miss_addr_q + {30'd0, cnt_q}) : ZERO_ADDR;
    assign fill_en   = rdy && (state_q == IC_FILL);
    assign fill_idx  = miss_addr_q[INDEX_W+1:2];
    assign fill_tag  = miss_addr_q[31:INDEX_W+2];
    assign fill_data = buf_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational lookup.
// Owns the valid/tag/data arrays; misses are refilled by icache_refill.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 32 - 2 - INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        cache_rd_en,
    input  logic [31:0] cache_rd_addr,
    output logic        cache_hit,
    output logic [31:0] cache_hit_inst,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_din
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    WORD_TP             data_mem [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               miss_start;
    logic               unused_addr_bits;

    logic               fill_en;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    WORD_TP             fill_data;

    assign idx              = cache_rd_addr[INDEX_W+1:2];
    assign tag              = cache_rd_addr[31:INDEX_W+2];
    assign unused_addr_bits = ^cache_rd_addr[1:0];

    // A line being installed this cycle is still invalid here: no fill bypass.
    assign cache_hit      = cache_rd_en && valid_q[idx] && (tag_mem[idx] == tag);
    assign cache_hit_inst = data_mem[idx];
    assign miss_start     = cache_rd_en && !cache_hit;

    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fill_idx] = TRUE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (rdy) begin
            valid_q <= valid_d;
        end
    end

    // Tag and data carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= fill_data;
        end
    end

    icache_refill #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .start      (miss_start),
        .start_addr (cache_rd_addr),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_din    (mem_din),
        .fill_en    (fill_en),
        .fill_idx   (fill_idx),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data)
    );

endmodule
